// File: rtl/ex_pipe_ctrl_if.sv
// ex_pipe_ctrl_if: hazard-detection inputs and stall/flush/forward controls
// exchanged between the pipeline datapath (master) and ex_pipe_ctrl (slave).
interface ex_pipe_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_mc_op;
  logic       id_mc_div;
  logic [4:0] ex_rd;
  logic       ex_wb_en;
  logic       ex_ld;
  logic [4:0] mem_rd;
  logic       mem_wb_en;
  logic       ex_flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       ex_hold;
  logic       flush_ifid;
  logic       mc_start;
  logic       mc_busy;
  logic       mc_abort;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_mc_op, id_mc_div,
           ex_rd, ex_wb_en, ex_ld, mem_rd, mem_wb_en, ex_flush,
    input  forward_a, forward_b, stall_if, stall_id, bubble_ex, ex_hold,
           flush_ifid, mc_start, mc_busy, mc_abort
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_mc_op, id_mc_div,
           ex_rd, ex_wb_en, ex_ld, mem_rd, mem_wb_en, ex_flush,
    output forward_a, forward_b, stall_if, stall_id, bubble_ex, ex_hold,
           flush_ifid, mc_start, mc_busy, mc_abort
  );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// ex_pipe_ctrl: EX-stage pipeline sequencer. Detects load-use hazards, registers
// operand forwarding selects into ID/EX, sequences multi-cycle fmul/fdiv by
// holding EX/MEM, and stretches a branch/jump redirect into a timed flush.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module ex_pipe_ctrl #(
  parameter int FMUL_LAT  = 4,
  parameter int FDIV_LAT  = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  ex_pipe_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int MAX_MC  = (FMUL_LAT > FDIV_LAT) ? FMUL_LAT : FDIV_LAT;
  localparam int MAX_CNT = (MAX_MC > FLUSH_CYC) ? MAX_MC : FLUSH_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MCBUSY  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mc_start_q, mc_start_d;
  logic               mc_abort_q, mc_abort_d;
  logic [1:0]         fwd_a_q, fwd_a_d;
  logic [1:0]         fwd_b_q, fwd_b_d;

  logic haz_a, haz_b, load_use;
  logic run_like, lu_mask;
  logic stall_if_c, stall_id_c, bubble_ex_c, ex_hold_c, flush_ifid_c, mc_busy_c;

  // Forward select for one source: EX result is youngest so it wins over EX/MEM.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] e_rd, input logic e_wb,
                                         input logic [4:0] m_rd, input logic m_wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != 5'd0) begin
      if (e_wb && (e_rd == rs)) begin
        sel = 2'b01;
      end else if (m_wb && (m_rd == rs)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Load-use detection; x0 is never a hazard.
  always_comb begin
    haz_a    = bus.id_use_rs1 && (bus.id_rs1 != 5'd0);
    haz_b    = bus.id_use_rs2 && (bus.id_rs2 != 5'd0);
    load_use = bus.ex_ld && bus.ex_wb_en && (bus.ex_rd != 5'd0) &&
               ((haz_a && (bus.id_rs1 == bus.ex_rd)) ||
                (haz_b && (bus.id_rs2 == bus.ex_rd)));
  end

  // Sequencer next-state and Mealy control outputs; everything is forced low in reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mc_start_d   = 1'b0;
    mc_abort_d   = 1'b0;
    stall_if_c   = 1'b0;
    stall_id_c   = 1'b0;
    bubble_ex_c  = 1'b0;
    ex_hold_c    = 1'b0;
    flush_ifid_c = 1'b0;
    mc_busy_c    = 1'b0;
    run_like     = 1'b0;
    lu_mask      = 1'b0;
    if (!rst) begin
      if (bus.ex_flush) begin
        flush_ifid_c = 1'b1;
        bubble_ex_c  = 1'b1;
        cnt_d        = CNT_W'(FLUSH_CYC - 1);
        state_d      = FLUSH;
        mc_abort_d   = (state_q == MCBUSY);
      end else begin
        case (state_q)
          RUN: run_like = 1'b1;
          LDSTALL: begin
            // The stall was already issued; the consumer now advances (it may itself be an FP op).
            run_like = 1'b1;
            lu_mask  = 1'b1;
          end
          MCBUSY: begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            // The mc_start cycle is the op's first EX cycle and does not count down.
            if (!mc_start_q) begin
              mc_busy_c = 1'b1;
              ex_hold_c = 1'b1;
              if (cnt_q == '0) begin
                state_d = RUN;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end
          FLUSH: begin
            if (cnt_q != '0) begin
              flush_ifid_c = 1'b1;
              bubble_ex_c  = 1'b1;
              cnt_d        = cnt_q - CNT_W'(1);
            end else begin
              run_like = 1'b1;
            end
          end
          default: state_d = RUN;
        endcase
        if (run_like) begin
          if (load_use && !lu_mask) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            bubble_ex_c = 1'b1;
            state_d     = LDSTALL;
          end else if (bus.id_mc_op) begin
            mc_start_d = 1'b1;
            cnt_d      = bus.id_mc_div ? CNT_W'(FDIV_LAT - 2) : CNT_W'(FMUL_LAT - 2);
            state_d    = MCBUSY;
          end else begin
            state_d = RUN;
          end
        end
      end
    end
  end

  // Forwarding selects follow the instruction into ID/EX: NOP on bubble, hold on stall.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (bubble_ex_c) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else if (!stall_id_c) begin
      fwd_a_d = fwd_sel(bus.id_rs1, bus.ex_rd, bus.ex_wb_en, bus.mem_rd, bus.mem_wb_en);
      fwd_b_d = fwd_sel(bus.id_rs2, bus.ex_rd, bus.ex_wb_en, bus.mem_rd, bus.mem_wb_en);
    end
  end

  // State, counter, pulse and forwarding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mc_start_q <= 1'b0;
      mc_abort_q <= 1'b0;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mc_start_q <= mc_start_d;
      mc_abort_q <= mc_abort_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

  assign bus.forward_a  = fwd_a_q;
  assign bus.forward_b  = fwd_b_q;
  assign bus.stall_if   = stall_if_c;
  assign bus.stall_id   = stall_id_c;
  assign bus.bubble_ex  = bubble_ex_c;
  assign bus.ex_hold    = ex_hold_c;
  assign bus.flush_ifid = flush_ifid_c;
  assign bus.mc_start   = mc_start_q;
  assign bus.mc_busy    = mc_busy_c;
  assign bus.mc_abort   = mc_abort_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters for stalled and flushed cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_id_c && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (flush_ifid_c && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
